// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-word layout, EX-stage state
// encoding and small decode helpers used by the pipeline stages.
package mips_pkg;

  // Control word {reg_write, mem_read, mem_write, memtoreg, alu_src,
  // reg_dst, alu_op[3:0]}, MSB first.
  localparam int CTRL_W         = 10;
  localparam int CTRL_REG_WRITE = 9;
  localparam int CTRL_MEM_READ  = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALU_SRC   = 5;
  localparam int CTRL_REG_DST   = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  // Architectural zero register; never a real data dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX occupancy state.
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ex_state_e;

  // Destination register selected by reg_dst: rd for R-type, rt otherwise.
  function automatic logic [4:0] sel_dest(input logic [CTRL_W-1:0] ctrl,
                                          input logic [4:0]        rt,
                                          input logic [4:0]        rd);
    logic [4:0] dest;
    if (ctrl[CTRL_REG_DST]) begin
      dest = rd;
    end else begin
      dest = rt;
    end
    return dest;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector. Flags an instruction in ID that
// reads the destination of a load currently in EX. Register 0 never
// participates. Shared with the branch-in-ID hazard logic.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_dest_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       lu_o
);

  logic src_match_s;

  // Hazard when a live load in EX writes a non-zero register that ID reads.
  always_comb begin
    src_match_s = 1'b0;
    lu_o        = 1'b0;
    if ((ex_dest_i == id_rs_i) || (ex_dest_i == id_rt_i)) begin
      src_match_s = 1'b1;
    end else begin
      src_match_s = 1'b0;
    end
    if (ex_valid_i && ex_mem_read_i && (ex_dest_i != REG_ZERO) &&
        id_valid_i && src_match_s) begin
      lu_o = 1'b1;
    end else begin
      lu_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core. Captures decoded operands and
// control, inserts a bubble on a load-use hazard or a flush, and drives the
// stall that holds PC and IF/ID.
// Optional feature macro: ID_EX_MULDIV_STALL_EN -- when defined, a MULT/DIV
// instruction stays in EX for MULDIV_LAT cycles (ex_busy/stall high for the
// first MULDIV_LAT-1 of them); when undefined every instruction takes one
// cycle in EX and ex_busy is tied low.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_muldiv,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic              ex_busy
);

  // Count loaded on mult/div entry; EX is held while it is non-zero.
  localparam logic [3:0] MD_HOLD_INIT = 4'(MULDIV_LAT - 1);

  logic              ex_valid_q,     ex_valid_d;
  logic [4:0]        ex_rs_q,        ex_rs_d;
  logic [4:0]        ex_rt_q,        ex_rt_d;
  logic [4:0]        ex_rd_q,        ex_rd_d;
  logic [DATA_W-1:0] ex_rs_val_q,    ex_rs_val_d;
  logic [DATA_W-1:0] ex_rt_val_q,    ex_rt_val_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
  logic              ex_is_muldiv_q, ex_is_muldiv_d;
  logic [3:0]        count_q,        count_d;
  ex_state_e         state_q,        state_d;

  logic [4:0]        ex_dest_s;
  logic              lu_s;
  logic              hold_s;
  logic              start_md_s;
  logic              unused_s;

  assign ex_dest_s = sel_dest(ex_ctrl_q, ex_rt_q, ex_rd_q);

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q[CTRL_MEM_READ]),
    .ex_dest_i     (ex_dest_s),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .lu_o          (lu_s)
  );

`ifdef ID_EX_MULDIV_STALL_EN
  // A mult/div keeps EX (and the ID stall) while its count is still running.
  always_comb begin
    hold_s = 1'b0;
    if ((state_q == MD_BUSY) && (count_q != 4'd0)) begin
      hold_s = 1'b1;
    end else begin
      hold_s = 1'b0;
    end
  end

  // A real mult/div entering EX arms the occupancy counter.
  always_comb begin
    start_md_s = 1'b0;
    if (id_valid && id_is_muldiv) begin
      start_md_s = 1'b1;
    end else begin
      start_md_s = 1'b0;
    end
  end

  assign ex_busy = (state_q == MD_BUSY);
`else
  assign hold_s     = 1'b0;
  assign start_md_s = 1'b0;
  assign ex_busy    = 1'b0;
`endif

  // Stall holds PC and IF/ID; a flush discards ID so it never stalls.
  always_comb begin
    stall = 1'b0;
    if (flush) begin
      stall = 1'b0;
    end else if (lu_s || hold_s) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Next-state selection: flush, then mult/div hold, then bubble, then capture.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_rd_d        = ex_rd_q;
    ex_rs_val_d    = ex_rs_val_q;
    ex_rt_val_d    = ex_rt_val_q;
    ex_imm_d       = ex_imm_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_is_muldiv_d = ex_is_muldiv_q;
    count_d        = count_q;
    state_d        = state_q;
    if (flush || (!hold_s && lu_s)) begin
      // Bubble; a flush also abandons any mult/div in progress.
      ex_valid_d     = 1'b0;
      ex_rs_d        = REG_ZERO;
      ex_rt_d        = REG_ZERO;
      ex_rd_d        = REG_ZERO;
      ex_rs_val_d    = {DATA_W{1'b0}};
      ex_rt_val_d    = {DATA_W{1'b0}};
      ex_imm_d       = {DATA_W{1'b0}};
      ex_ctrl_d      = {CTRL_W{1'b0}};
      ex_is_muldiv_d = 1'b0;
      count_d        = 4'd0;
      state_d        = RUN;
    end else if (hold_s) begin
      // Keep every EX field; the last count step hands EX back to RUN,
      // which then loads the waiting ID instruction one edge later.
      count_d = count_q - 4'd1;
      if (count_q == 4'd1) begin
        state_d = RUN;
      end else begin
        state_d = MD_BUSY;
      end
    end else begin
      ex_valid_d     = id_valid;
      ex_rs_d        = id_rs;
      ex_rt_d        = id_rt;
      ex_rd_d        = id_rd;
      ex_rs_val_d    = id_rs_val;
      ex_rt_val_d    = id_rt_val;
      ex_imm_d       = id_imm;
      ex_ctrl_d      = id_valid ? id_ctrl : {CTRL_W{1'b0}};
      ex_is_muldiv_d = id_valid && id_is_muldiv;
      if (start_md_s) begin
        count_d = MD_HOLD_INIT;
        state_d = MD_BUSY;
      end else begin
        count_d = 4'd0;
        state_d = RUN;
      end
    end
  end

  // EX pipeline registers with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= REG_ZERO;
      ex_rt_q        <= REG_ZERO;
      ex_rd_q        <= REG_ZERO;
      ex_rs_val_q    <= {DATA_W{1'b0}};
      ex_rt_val_q    <= {DATA_W{1'b0}};
      ex_imm_q       <= {DATA_W{1'b0}};
      ex_ctrl_q      <= {CTRL_W{1'b0}};
      ex_is_muldiv_q <= 1'b0;
      count_q        <= 4'd0;
      state_q        <= RUN;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs_val_q    <= ex_rs_val_d;
      ex_rt_val_q    <= ex_rt_val_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_is_muldiv_q <= ex_is_muldiv_d;
      count_q        <= count_d;
      state_q        <= state_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_dest   = ex_dest_s;
  assign ex_rs_val = ex_rs_val_q;
  assign ex_rt_val = ex_rt_val_q;
  assign ex_imm    = ex_imm_q;
  assign ex_ctrl   = ex_ctrl_q;

  // Fields kept for downstream and debug use that this stage does not read
  // in every build.
  assign unused_s = ^{ex_is_muldiv_q, state_q, count_q, id_is_muldiv,
                      MD_HOLD_INIT};

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by biased
// random traffic, all compared against a cycle-level reference model.
module tb_id_ex_stage;

  localparam int DATA_W     = 32;
  localparam int MULDIV_LAT = 4;
`ifdef ID_EX_MULDIV_STALL_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  localparam logic [9:0] C_LW   = 10'b1101100000;
  localparam logic [9:0] C_ADD  = 10'b1000010010;
  localparam logic [9:0] C_MULT = 10'b0000010110;

  logic              clk = 1'b0;
  logic              reset, id_valid, id_is_muldiv, flush;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_val, id_rt_val, id_imm;
  logic [9:0]        id_ctrl;
  logic              ex_valid, stall, ex_busy;
  logic [4:0]        ex_rs, ex_rt, ex_dest;
  logic [DATA_W-1:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [9:0]        ex_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_muldiv(id_is_muldiv), .flush(flush), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall(stall), .ex_busy(ex_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model of what EX holds, plus the number of stall cycles
  // still owed to a mult/div occupying EX.
  bit                m_known = 1'b0;
  bit                m_valid;
  logic [4:0]        m_rs, m_rt, m_rd;
  logic [DATA_W-1:0] m_rsv, m_rtv, m_imm;
  logic [9:0]        m_ctrl;
  int                m_left = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_bubble();
    m_valid = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    m_rsv = '0; m_rtv = '0; m_imm = '0; m_ctrl = 10'd0;
  endtask

  // Compare DUT against the model for the current cycle, advance the model
  // across the coming edge, and return at the following falling edge.
  task automatic step();
    logic [4:0] d;
    bit lu, hold, e_stall;
    #1;
    d       = m_ctrl[4] ? m_rd : m_rt;
    lu      = m_valid && m_ctrl[8] && (d != 5'd0) && id_valid &&
              ((d == id_rs) || (d == id_rt));
    hold    = (m_left > 0);
    e_stall = !flush && (lu || hold);
    if (m_known) begin
      check_val("ex_valid",  64'(ex_valid),  64'(m_valid));
      check_val("ex_ctrl",   64'(ex_ctrl),   64'(m_ctrl));
      check_val("ex_rs",     64'(ex_rs),     64'(m_rs));
      check_val("ex_rt",     64'(ex_rt),     64'(m_rt));
      check_val("ex_dest",   64'(ex_dest),   64'(d));
      check_val("ex_rs_val", 64'(ex_rs_val), 64'(m_rsv));
      check_val("ex_rt_val", 64'(ex_rt_val), 64'(m_rtv));
      check_val("ex_imm",    64'(ex_imm),    64'(m_imm));
      check_val("stall",     64'(stall),     64'(e_stall));
      check_val("ex_busy",   64'(ex_busy),   64'(hold));
    end
    if (reset || flush) begin
      m_bubble(); m_left = 0; m_known = 1'b1;
    end else if (hold) begin
      m_left--;
    end else if (lu) begin
      m_bubble();
    end else begin
      m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_rsv = id_rs_val; m_rtv = id_rt_val; m_imm = id_imm;
      m_ctrl = id_valid ? id_ctrl : 10'd0;
      if (MD_ON && id_valid && id_is_muldiv) m_left = MULDIV_LAT - 1;
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [9:0] ctrl,
                        input bit md);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    id_is_muldiv = md;
    id_rs_val = $urandom; id_rt_val = $urandom; id_imm = $urandom;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, C_ADD, 1'b0);
    @(negedge clk);

    // Reset held two cycles with a valid instruction waiting in ID.
    step(); step();
    reset = 1'b0;
    #1;
    check_val("rst_valid", 64'(ex_valid), 64'd0);
    check_val("rst_ctrl",  64'(ex_ctrl),  64'd0);
    check_val("rst_dest",  64'(ex_dest),  64'd0);
    check_val("rst_stall", 64'(stall),    64'd0);
    check_val("rst_busy",  64'(ex_busy),  64'd0);
    step();
    check_val("post_rst_capture", 64'(ex_valid), 64'd1);

    // Load-use: lw $8 in EX, add reading $8 in ID.
    set_id(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
    step();
    set_id(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b0);
    #1;
    check_val("lu_stall", 64'(stall), 64'd1);
    step();
    check_val("lu_bubble", 64'(ex_valid), 64'd0);
    check_val("lu_clear",  64'(stall),    64'd0);
    step();
    check_val("lu_add_in_ex", 64'(ex_rs), 64'd8);
    check_val("lu_add_valid", 64'(ex_valid), 64'd1);

    // Zero register: lw $0 never stalls.
    set_id(1'b1, 5'd1, 5'd0, 5'd0, C_LW, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, C_ADD, 1'b0);
    #1;
    check_val("zero_stall", 64'(stall), 64'd0);
    step();
    check_val("zero_no_bubble", 64'(ex_valid), 64'd1);

    // Flush beats load-use.
    set_id(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
    step();
    set_id(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b0);
    flush = 1'b1;
    #1;
    check_val("flush_stall", 64'(stall), 64'd0);
    step();
    flush = 1'b0;
    check_val("flush_bubble", 64'(ex_valid), 64'd0);

    // Mult/div occupancy.
    set_id(1'b1, 5'd3, 5'd4, 5'd0, C_MULT, 1'b1);
    step();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, C_ADD, 1'b0);
`ifdef ID_EX_MULDIV_STALL_EN
    for (int i = 0; i < MULDIV_LAT - 1; i++) begin
      #1;
      check_val("md_busy",  64'(ex_busy), 64'd1);
      check_val("md_stall", 64'(stall),   64'd1);
      check_val("md_rs",    64'(ex_rs),   64'd3);
      check_val("md_rt",    64'(ex_rt),   64'd4);
      step();
    end
    #1;
    check_val("md_last_busy", 64'(ex_busy), 64'd0);
    check_val("md_last_rs",   64'(ex_rs),   64'd3);
    step();
    check_val("md_next_in", 64'(ex_rs), 64'd5);

    // Flush on the second busy cycle.
    set_id(1'b1, 5'd3, 5'd4, 5'd0, C_MULT, 1'b1);
    step();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 10'd0, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check_val("mdflush_busy",  64'(ex_busy),  64'd0);
    check_val("mdflush_valid", 64'(ex_valid), 64'd0);
    check_val("mdflush_stall", 64'(stall),    64'd0);
    step();
`else
    #1;
    check_val("nomd_busy",  64'(ex_busy), 64'd0);
    check_val("nomd_stall", 64'(stall),   64'd0);
    step();
    check_val("nomd_next_in", 64'(ex_rs), 64'd5);
`endif

    // Biased random traffic: few register numbers so hazards are common.
    for (int n = 0; n < 3000; n++) begin
      logic [9:0] c;
      c = 10'($urandom);
      c[8] = ($urandom_range(0, 1) == 0);
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), c,
             $urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
